// File: rtl/seq_gen_tx.sv
// Serial "1001" pattern transmitter with a mirror detector on its own X line.
// Optional even-parity bit per word: define SEQ_GEN_TX_PARITY_EN.
module seq_gen_tx #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DIN,
  input  logic             DIN_VALID,
  output logic             DIN_READY,
  output logic             X,
  output logic             X_VALID,
  output logic             BUSY,
  output logic             HIT,
  output logic [1:0]       HIT_CNT,
  output logic             GROUP
);

  localparam int CNT_W    = $clog2(WIDTH + 1);
  localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2, GAP = 2'd3} state_t;
  typedef enum logic [1:0] {M0 = 2'd0, M1 = 2'd1, M2 = 2'd2, M3 = 2'd3} mstate_t;

  state_t           state_r;
  mstate_t          mir_r;
  mstate_t          mir_nxt_s;
  logic [WIDTH-1:0] shift_r;
  logic [CNT_W-1:0] bit_cnt_r;
  logic [GAP_W-1:0] gap_cnt_r;
  logic             accept_s;
  logic             x_nxt_s;
  logic             hit_nxt_s;

`ifdef SEQ_GEN_TX_PARITY_EN
  logic par_r;

  function automatic logic even_par(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction
`endif

  assign DIN_READY = (state_r == IDLE) && !RST;
  assign accept_s  = DIN_VALID && DIN_READY;

  // Value that the next edge drives onto X; the mirror detector consumes it too.
  always_comb begin
    x_nxt_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) x_nxt_s = DIN[WIDTH-1];
        else          x_nxt_s = 1'b0;
      end
      SHIFT: begin
        if (bit_cnt_r == LAST_BIT) begin
`ifdef SEQ_GEN_TX_PARITY_EN
          x_nxt_s = par_r;
`else
          x_nxt_s = 1'b0;
`endif
        end else begin
          x_nxt_s = shift_r[WIDTH-1];
        end
      end
      default: x_nxt_s = 1'b0;
    endcase
  end

  // Overlapping "1001" recogniser: the closing 1 lands in M1 to start the next match.
  always_comb begin
    mir_nxt_s = M0;
    hit_nxt_s = 1'b0;
    case (mir_r)
      M0:      mir_nxt_s = x_nxt_s ? M1 : M0;
      M1:      mir_nxt_s = x_nxt_s ? M1 : M2;
      M2:      mir_nxt_s = x_nxt_s ? M1 : M3;
      M3: begin
        mir_nxt_s = x_nxt_s ? M1 : M0;
        hit_nxt_s = x_nxt_s;
      end
      default: mir_nxt_s = M0;
    endcase
  end

  // Transmit FSM, mirror state and hit counting with registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r   <= IDLE;
      mir_r     <= M0;
      shift_r   <= {WIDTH{1'b0}};
      bit_cnt_r <= {CNT_W{1'b0}};
      gap_cnt_r <= {GAP_W{1'b0}};
      X         <= 1'b0;
      X_VALID   <= 1'b0;
      BUSY      <= 1'b0;
      HIT       <= 1'b0;
      HIT_CNT   <= 2'd0;
      GROUP     <= 1'b0;
`ifdef SEQ_GEN_TX_PARITY_EN
      par_r     <= 1'b0;
`endif
    end else begin
      X     <= x_nxt_s;
      mir_r <= mir_nxt_s;
      HIT   <= hit_nxt_s;
      if (hit_nxt_s) begin
        if (HIT_CNT == 2'd2) begin
          HIT_CNT <= 2'd0;
          GROUP   <= 1'b1;
        end else begin
          HIT_CNT <= HIT_CNT + 2'd1;
          GROUP   <= 1'b0;
        end
      end else begin
        GROUP <= 1'b0;
      end

      case (state_r)
        IDLE: begin
          if (accept_s) begin
            shift_r   <= DIN << 1;
            bit_cnt_r <= CNT_W'(1);
            X_VALID   <= 1'b1;
            BUSY      <= 1'b1;
            state_r   <= SHIFT;
`ifdef SEQ_GEN_TX_PARITY_EN
            par_r     <= even_par(DIN);
`endif
          end else begin
            X_VALID <= 1'b0;
            BUSY    <= 1'b0;
          end
        end
        SHIFT: begin
          if (bit_cnt_r == LAST_BIT) begin
`ifdef SEQ_GEN_TX_PARITY_EN
            state_r <= PAR;
            X_VALID <= 1'b1;
            BUSY    <= 1'b1;
`else
            X_VALID <= 1'b0;
            if (GAP_CYCLES > 0) begin
              state_r   <= GAP;
              gap_cnt_r <= GAP_W'(GAP_LOAD);
              BUSY      <= 1'b1;
            end else begin
              state_r <= IDLE;
              BUSY    <= 1'b0;
            end
`endif
          end else begin
            shift_r   <= shift_r << 1;
            bit_cnt_r <= bit_cnt_r + CNT_W'(1);
            X_VALID   <= 1'b1;
            BUSY      <= 1'b1;
          end
        end
        PAR: begin
          X_VALID <= 1'b0;
          if (GAP_CYCLES > 0) begin
            state_r   <= GAP;
            gap_cnt_r <= GAP_W'(GAP_LOAD);
            BUSY      <= 1'b1;
          end else begin
            state_r <= IDLE;
            BUSY    <= 1'b0;
          end
        end
        GAP: begin
          X_VALID <= 1'b0;
          if (gap_cnt_r == {GAP_W{1'b0}}) begin
            state_r <= IDLE;
            BUSY    <= 1'b0;
          end else begin
            gap_cnt_r <= gap_cnt_r - GAP_W'(1);
            BUSY      <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          X_VALID <= 1'b0;
          BUSY    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_gen_tx.sv
// Self-checking bench for seq_gen_tx: per-cycle scoreboard of the X line
// plus a table of words with hand-derived hit/group counts.
module tb_seq_gen_tx;

  localparam int W  = 8;
  localparam int G  = 2;
  localparam int G1 = 1;
`ifdef SEQ_GEN_TX_PARITY_EN
  localparam int PE = 1;
`else
  localparam int PE = 0;
`endif

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] DIN, DIN_B;
  logic       DIN_VALID, DIN_VALID_B;
  logic       DIN_READY, X, X_VALID, BUSY, HIT, GROUP;
  logic       DIN_READY_B, X_B, X_VALID_B, BUSY_B, HIT_B, GROUP_B;
  logic [1:0] HIT_CNT, HIT_CNT_B;

  seq_gen_tx #(.WIDTH(W), .GAP_CYCLES(G)) dut (
    .CLK(CLK), .RST(RST), .DIN(DIN), .DIN_VALID(DIN_VALID), .DIN_READY(DIN_READY),
    .X(X), .X_VALID(X_VALID), .BUSY(BUSY), .HIT(HIT), .HIT_CNT(HIT_CNT), .GROUP(GROUP)
  );

  seq_gen_tx #(.WIDTH(W), .GAP_CYCLES(G1)) dut_b (
    .CLK(CLK), .RST(RST), .DIN(DIN_B), .DIN_VALID(DIN_VALID_B), .DIN_READY(DIN_READY_B),
    .X(X_B), .X_VALID(X_VALID_B), .BUSY(BUSY_B), .HIT(HIT_B), .HIT_CNT(HIT_CNT_B),
    .GROUP(GROUP_B)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       x;
    logic       xv;
    logic       busy;
    logic       hit;
    logic [1:0] cnt;
    logic       grp;
  } exp_t;

  typedef struct {
    logic [7:0] din;
    int         hits;
    int         grps;
    int         cnt;
  } vec_t;

  exp_t       exp_q[$];
  logic [3:0] m_hist = 4'b0000;
  int         m_cnt  = 0;
  int         errors = 0;
  int         checks = 0;
  vec_t       tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  // Line model: last four X bits equal to 1001 means a hit.
  task automatic push_exp(input logic x, input logic xv, input logic busy);
    exp_t e;
    logic g;
    m_hist = {m_hist[2:0], x};
    e.hit  = (m_hist == 4'b1001);
    g      = 1'b0;
    if (e.hit) begin
      if (m_cnt == 2) begin
        m_cnt = 0;
        g     = 1'b1;
      end else begin
        m_cnt++;
      end
    end
    e.x    = x;
    e.xv   = xv;
    e.busy = busy;
    e.cnt  = 2'(m_cnt);
    e.grp  = g;
    exp_q.push_back(e);
  endtask

  task automatic cycle();
    exp_t       e;
    logic [7:0] act, want;
    if (RST) begin
      exp_q.delete();
      m_hist = 4'b0000;
      m_cnt  = 0;
    end
    @(posedge CLK);
    @(negedge CLK);
    if (exp_q.size() == 0) push_exp(1'b0, 1'b0, 1'b0);
    e    = exp_q.pop_front();
    act  = {X, X_VALID, BUSY, HIT, HIT_CNT, GROUP, DIN_READY};
    want = {e.x, e.xv, e.busy, e.hit, e.cnt, e.grp, (!e.busy && !RST)};
    check("cycle{X,XV,BUSY,HIT,CNT,GRP,RDY}", act, want);
  endtask

  task automatic send_word(input logic [7:0] w, input bit hold,
                           input int eh, input int eg, input int ec);
    int hits = 0;
    int grps = 0;
    DIN       = w;
    DIN_VALID = 1'b1;
    for (int i = 0; i < W; i++) push_exp(w[W-1-i], 1'b1, 1'b1);
    if (PE != 0) push_exp(^w, 1'b1, 1'b1);
    for (int i = 0; i < G; i++) push_exp(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < W + PE + G; i++) begin
      cycle();
      hits += int'(HIT);
      grps += int'(GROUP);
      if (hold && i < W - 1) DIN = 8'($urandom);
      else                   DIN_VALID = 1'b0;
    end
    cycle();
    if (eh >= 0) begin
      check("word_hits", hits, eh);
      check("word_groups", grps, eg);
      check("word_hit_cnt", HIT_CNT, ec);
    end
  endtask

  initial begin
    // Hand-derived from an all-zero line; all words have even parity so the
    // optional parity bit is a zero and cannot create extra hits.
    tbl[0] = '{8'h90, 1, 0, 1};
    tbl[1] = '{8'h93, 2, 1, 0};
    tbl[2] = '{8'h99, 2, 0, 2};
    tbl[3] = '{8'h00, 0, 0, 2};
    tbl[4] = '{8'h24, 1, 1, 0};
    tbl[5] = '{8'hFF, 0, 0, 0};
    tbl[6] = '{8'h09, 1, 0, 1};

    RST         = 1'b1;
    DIN         = 8'hFF;
    DIN_VALID   = 1'b1;
    DIN_B       = 8'h00;
    DIN_VALID_B = 1'b0;
    cycle();
    cycle();
    RST       = 1'b0;
    DIN_VALID = 1'b0;
    cycle();
    check("ready_after_reset", DIN_READY, 1'b1);

    for (int i = 0; i < 7; i++) send_word(tbl[i].din, 1'b0, tbl[i].hits, tbl[i].grps, tbl[i].cnt);

    // Overlap then group, with DIN_VALID held and DIN churning during SHIFT.
    send_word(8'h92, 1'b1, -1, 0, 0);
    send_word(8'h90, 1'b0, -1, 0, 0);

    send_word(8'h07, 1'b0, -1, 0, 0);
    send_word(8'h03, 1'b0, -1, 0, 0);

    // Cross-word hit on the single-gap instance: valid stays high until the second accept.
    DIN_B       = 8'h01;
    DIN_VALID_B = 1'b1;
    for (int i = 0; i < W + PE + G1 + 4; i++) begin
      cycle();
      check("xword_hit", HIT_B, (i == W + PE + G1 + 1) ? 1'b1 : 1'b0);
      DIN_B = 8'h80;
      if (i == W + PE + G1 + 1) DIN_VALID_B = 1'b0;
    end

    // Mid-word reset asserted for the edge that would present bit 4.
    DIN       = 8'h90;
    DIN_VALID = 1'b1;
    for (int i = 0; i < W; i++) push_exp(DIN[W-1-i], 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle();
      DIN_VALID = 1'b0;
    end
    check("hit_before_reset", HIT, 1'b1);
    RST = 1'b1;
    cycle();
    check("cnt_in_reset", HIT_CNT, 2'd0);
    RST = 1'b0;
    for (int i = 0; i < 12; i++) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_gen_tx.md
# seq_gen_tx

Serial pattern transmitter: the driving end of the single-bit `X` line consumed by the "1001" sequence detector.
- Accepts parallel words over a valid/ready handshake and shifts them out MSB-first, one bit per `CLK`, followed by zero-filled gap cycles.
- A mirror detector runs on its own `X` stream and flags every overlapping "1001" it emits (`HIT`). It also flags every third hit (`GROUP`).
- The bench compares `HIT`/`GROUP` against the receiver's `Z1`/`Z2`.

## Interface
- `WIDTH`, 8: data bits per word, ≥ 2.
- `GAP_CYCLES`, 2: forced-zero cycles after each word, ≥ 0.

- `CLK`  in  1  clock, rising-edge.
- `RST`  in  1  reset, synchronous, active-high.
- `DIN`  in  WIDTH  word to transmit, sampled on acceptance.
- `DIN_VALID`  in  1  word offered.
- `DIN_READY`  out  1  block can accept; equals (state==IDLE) && !RST.
- `X`  out  1  serial line, registered.
- `X_VALID`  out  1  registered; high when `X` carries a data or parity bit.
- `BUSY`  out  1  registered; high in SHIFT, PAR, GAP.
- `HIT`  out  1  registered one-cycle pulse, coincident with the `X` bit that completes "1001".
- `HIT_CNT`  out  2  hits modulo 3.
- `GROUP`  out  1  registered one-cycle pulse, coincident with the third `HIT`.

## Operation
- **Reset values:** `X`=0, `X_VALID`=0, `BUSY`=0, `HIT`=0, `GROUP`=0, `HIT_CNT`=0, state IDLE, mirror M0.
  - Reset wins over every other event, including mid-word; the in-flight word is discarded.
- **Acceptance:** a word is accepted at an edge where `DIN_VALID` && `DIN_READY`; `DIN` is latched into the shift register.
  - `DIN_VALID` outside IDLE is ignored.
  - `DIN` changes after acceptance have no effect.
- **Transmit FSM:**
  - IDLE: `X`=0, `X_VALID`=0. On acceptance, `X` ← `DIN[WIDTH-1]`, `X_VALID` ← 1, go to SHIFT.
  - SHIFT: one bit per cycle, WIDTH cycles total. On the last bit, go to PAR if the parity macro is defined; otherwise GAP if `GAP_CYCLES`>0; otherwise IDLE.
  - PAR: one cycle with `X` = even parity of the word (XOR of all `DIN` bits), `X_VALID`=1. Then go to GAP or IDLE.
  - GAP: `GAP_CYCLES` cycles with `X`=0, `X_VALID`=0, then IDLE.
  - Bit counter width is clog2(WIDTH+1).
- **Mirror detector:**
  - Advances on every value driven onto `X`, including IDLE and GAP zeros, because the receiver sees those too.
  - Updated at the same edge that loads `X`.
  - States and transitions:
    - M0 (nothing): 1→M1, 0→M0.
    - M1 ("1"): 1→M1, 0→M2.
    - M2 ("10"): 1→M1, 0→M3.
    - M3 ("100"): 1→M1 with `HIT`, 0→M0.
  - Detection overlaps: the closing 1 of a hit starts the next match.
- **Hit counting:**
  - On each `HIT`, `HIT_CNT` increments.
  - The hit that would make `HIT_CNT` 3 pulses `GROUP` and sets `HIT_CNT` to 0 in the same edge.

## Timing
- Accept at edge k: first bit is on `X` from edge k until edge k+1. Bit i (MSB = 0) occupies cycle k+i.
- Word period: 1 (IDLE) + WIDTH + P + `GAP_CYCLES` cycles, where P is 1 with parity and 0 without. Default is 11 cycles without parity.
- `DIN_READY` is high only in IDLE; there is no back-to-back acceptance. IDLE always inserts one zero on `X`.
- `HIT` and `GROUP` are aligned with `X`. The receiver's `Z1` follows `HIT` by exactly one cycle.
- Reset at edge r: all outputs hold reset values from edge r. `DIN_READY` is 0 while `RST`=1 and 1 in the cycle after `RST` drops.

## Configuration
- `SEQ_GEN_TX_PARITY_EN`
  - **Defined:** PAR state is compiled in and appends one even-parity bit per word. The parity bit has `X_VALID`=1 and feeds the mirror detector.
  - **Undefined:** no PAR state; GAP follows the last data bit directly.

## Test plan
- **Reset:** `RST`=1 for 2 cycles while `DIN_VALID`=1 → all outputs 0, no acceptance. `DIN_READY`=1 in the first cycle after `RST`=0.
- **Single hit:** `DIN`=8'b1001_0000, no parity → `X` = 1,0,0,1,0,0,0,0 then 2 gap zeros. `X_VALID` high for 8 cycles. `HIT` on bit 3, `HIT_CNT`=1, `BUSY` low after 10 cycles.
- **Overlap and group:** words 8'b1001_0010 then 8'h90 → `HIT` on bits 3 and 6 of the first word (`HIT_CNT` 1→2), then bit 3 of the second word gives `GROUP`=1 and `HIT_CNT`=0.
- **Cross-word hit:** `GAP_CYCLES`=1, word 8'h01 then 8'h80 → line reads 1, gap 0, idle 0, 1 → `HIT` on the first bit of the second word.
- **Hold-off and mid-word reset:** `DIN_VALID` held high through SHIFT with `DIN` changing → no second acceptance. `RST` at bit 4 → `X`=0, `X_VALID`=0, `HIT_CNT`=0 next cycle, and the word is not resumed.
- **Parity (macro defined):** `DIN`=8'b0000_0111 → 9th bit on `X` is 1 with `X_VALID`=1. `DIN`=8'h03 → 9th bit is 0.
